pc_next_unit: RTL and testbench

//   Program-counter / next-PC stage of the KGP-RISC core; directly downstream of BranchCheck.

---
 rtl/pc_next_unit.sv | 177 +++++++++++++++++
 tb/tb_pc_next_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC selection and req/ack instruction fetch for the KGP-RISC core.
// Optional feature macro PC_MISALIGN_TRAP_EN adds misalign_trap and refuses unaligned redirect targets.
module pc_next_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_flag,
  input  logic [31:0]       br_offset,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              link_en,
  input  logic [ADDR_W-1:0] ctl_pc,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              taken,
  output logic [ADDR_W-1:0] link_addr
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic              misalign_trap
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam int SUM_W = (ADDR_W > 32) ? ADDR_W : 32;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              req_q, req_d;
  logic              flush_q, flush_d;
  logic              taken_q, taken_d;

  logic [SUM_W-1:0]  br_sum_s;
  logic [ADDR_W-1:0] raw_tgt_s;
  logic [ADDR_W-1:0] tgt_s;
  logic              redir_s;
  logic              bad_tgt_s;
  logic              halt_s;
  logic              go_s;

  assign br_sum_s  = SUM_W'(ctl_pc) + SUM_W'(32'd4) + (SUM_W'($signed(br_offset)) << 2);
  assign redir_s   = jmp_valid | (br_valid & br_flag);
  assign raw_tgt_s = jmp_valid ? jmp_target : br_sum_s[ADDR_W-1:0];

`ifdef PC_MISALIGN_TRAP_EN
  logic trap_q, trap_d;

  assign bad_tgt_s = |raw_tgt_s[1:0];
  assign tgt_s     = raw_tgt_s;
  assign halt_s    = trap_q;

  // Trap is sticky: any refused redirect outside REDIRECT latches it until reset.
  always_comb begin
    trap_d = trap_q | (redir_s & bad_tgt_s & (state_q != ST_REDIRECT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign misalign_trap = trap_q;
`else
  assign bad_tgt_s = 1'b0;
  assign tgt_s     = raw_tgt_s & ~ADDR_W'(32'd3);
  assign halt_s    = 1'b0;
`endif

  assign go_s = en & ~stall & ~halt_s;

  // Next-state logic; a redirect seen with a fetch still pending parks in REDIRECT until that ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    link_d  = link_q;
    req_d   = req_q;
    flush_d = 1'b0;
    taken_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_FETCH: begin
        if (redir_s && bad_tgt_s) begin
          flush_d = 1'b1;
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end else if (redir_s) begin
          flush_d = 1'b1;
          taken_d = 1'b1;
          if (jmp_valid && link_en) begin
            link_d = ctl_pc + ADDR_W'(32'd4);
          end else begin
            link_d = link_q;
          end
          if ((state_q == ST_FETCH) && !imem_ack) begin
            state_d = ST_REDIRECT;
            tgt_d   = tgt_s;
            req_d   = 1'b1;
          end else begin
            pc_d    = tgt_s;
            state_d = go_s ? ST_FETCH : ST_IDLE;
            req_d   = go_s;
          end
        end else if ((state_q == ST_FETCH) && imem_ack) begin
          pc_d    = pc_q + ADDR_W'(32'd4);
          state_d = go_s ? ST_FETCH : ST_IDLE;
          req_d   = go_s;
        end else if ((state_q == ST_IDLE) && go_s) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
        end else begin
          state_d = state_q;
          req_d   = req_q;
        end
      end
      ST_REDIRECT: begin
        if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = go_s ? ST_FETCH : ST_IDLE;
          req_d   = go_s;
        end else begin
          state_d = ST_REDIRECT;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      link_q  <= {ADDR_W{1'b0}};
      req_q   <= 1'b0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      link_q  <= link_d;
      req_q   <= req_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign flush     = flush_q;
  assign taken     = taken_q;
  assign link_addr = link_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit (default build, PC_MISALIGN_TRAP_EN undefined).
module tb_pc_next_unit;
  logic        clk = 1'b0;
  logic        rst, en, stall, br_valid, br_flag, jmp_valid, link_en, imem_ack;
  logic [31:0] br_offset, jmp_target, ctl_pc;
  logic        imem_req, flush, taken;
  logic [31:0] imem_addr, pc, link_addr;
  int          checks = 0;
  int          errors = 0;

  pc_next_unit dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .br_valid(br_valid), .br_flag(br_flag),
    .br_offset(br_offset), .jmp_valid(jmp_valid), .jmp_target(jmp_target), .link_en(link_en),
    .ctl_pc(ctl_pc), .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .flush(flush), .taken(taken), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    br_valid = 1'b0; br_flag = 1'b0; br_offset = 32'h0;
    jmp_valid = 1'b0; jmp_target = 32'h0; link_en = 1'b0; ctl_pc = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    clear_ctl();
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if ({flush, taken} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {flush, taken}); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL reset_link got %h exp 0", link_addr); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    en = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * i)); end
      checks++; if ({imem_req, flush} !== 2'b10) begin errors++; $display("FAIL seq_req_flush[%0d] got %b exp 10", i, {imem_req, flush}); end
    end
  endtask

  task automatic test_ack_wait();
    jmp_valid = 1'b1; jmp_target = 32'h40;
    tick();
    clear_ctl();
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL jmp40_addr got %h exp 40", imem_addr); end
    checks++; if (taken !== 1'b1) begin errors++; $display("FAIL jmp40_taken got %b exp 1", taken); end
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL wait_hold[%0d] got %b/%h exp 1/40", i, imem_req, imem_addr); end
    end
    imem_ack = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL wait_adv got %h exp 44", imem_addr); end
  endtask

  task automatic test_branch();
    br_valid = 1'b1; br_flag = 1'b1; ctl_pc = 32'h100; br_offset = 32'hFFFF_FFFE;
    tick();
    clear_ctl();
    checks++; if ({taken, flush} !== 2'b11) begin errors++; $display("FAIL br_pulse got %b exp 11", {taken, flush}); end
    checks++; if (imem_addr !== 32'hFC) begin errors++; $display("FAIL br_addr got %h exp fc", imem_addr); end
    tick();
    checks++; if ({taken, flush} !== 2'b00) begin errors++; $display("FAIL br_pulse_end got %b exp 00", {taken, flush}); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL br_next got %h exp 100", imem_addr); end
    br_valid = 1'b1; br_flag = 1'b0; ctl_pc = 32'h100; br_offset = 32'h10;
    tick();
    clear_ctl();
    checks++; if ({imem_addr, taken} !== {32'h104, 1'b0}) begin errors++; $display("FAIL br_nt got %h/%b exp 104/0", imem_addr, taken); end
  endtask

  task automatic test_jump_link();
    jmp_valid = 1'b1; link_en = 1'b1; jmp_target = 32'h200; ctl_pc = 32'h80;
    br_valid = 1'b1; br_flag = 1'b1; br_offset = 32'h5;
    tick();
    clear_ctl();
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL jl_addr got %h exp 200", imem_addr); end
    checks++; if (link_addr !== 32'h84) begin errors++; $display("FAIL jl_link got %h exp 84", link_addr); end
    tick();
    checks++; if ({imem_addr, link_addr, taken} !== {32'h204, 32'h84, 1'b0}) begin errors++; $display("FAIL jl_after got %h/%h/%b exp 204/84/0", imem_addr, link_addr, taken); end
  endtask

  task automatic test_redirect_pending();
    imem_ack = 1'b0;
    tick();
    br_valid = 1'b1; br_flag = 1'b1; ctl_pc = 32'h300; br_offset = 32'h4;
    tick();
    clear_ctl();
    checks++; if ({taken, flush, imem_req, imem_addr} !== {3'b111, 32'h204}) begin errors++; $display("FAIL pend_accept got %b%b%b/%h exp 111/204", taken, flush, imem_req, imem_addr); end
    jmp_valid = 1'b1; jmp_target = 32'h500;
    tick();
    clear_ctl();
    checks++; if ({taken, imem_req, imem_addr} !== {2'b01, 32'h204}) begin errors++; $display("FAIL pend_hold got %b%b/%h exp 01/204", taken, imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h314}) begin errors++; $display("FAIL pend_target got %b/%h exp 1/314", imem_req, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h318) begin errors++; $display("FAIL pend_next got %h exp 318", imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h31C}) begin errors++; $display("FAIL stall_idle got %b/%h exp 0/31c", imem_req, imem_addr); end
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h31C}) begin errors++; $display("FAIL stall_hold got %b/%h exp 0/31c", imem_req, imem_addr); end
    stall = 1'b0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h31C}) begin errors++; $display("FAIL stall_release got %b/%h exp 1/31c", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick();
    clear_ctl();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", pc); end
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    tick();
    imem_ack = 1'b0;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL mid_pending got %b/%h exp 1/4", imem_req, imem_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({imem_req, pc, link_addr} !== {1'b0, 32'h0, 32'h0}) begin errors++; $display("FAIL mid_reset got %b/%h/%h exp 0/0/0", imem_req, pc, link_addr); end
  endtask

  task automatic test_idle_redirect_align();
    en = 1'b0;
    jmp_valid = 1'b1; jmp_target = 32'h83;
    tick();
    clear_ctl();
    checks++; if ({imem_req, taken, pc} !== {2'b01, 32'h80}) begin errors++; $display("FAIL idle_jmp got %b%b/%h exp 01/80", imem_req, taken, pc); end
    en = 1'b1;
    tick();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL idle_start got %b/%h exp 1/80", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_wait();
    test_branch();
    test_jump_link();
    test_redirect_pending();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    test_idle_redirect_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
